// File: rtl/mem_port_arbiter.sv
// Shares one multi-cycle backing memory between the fetch and data ports.
// Data wins ties unless it won the previous grant, so fetch cannot starve.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  inst_read,
  input  logic [ADDR_WIDTH-1:0] inst_address,
  output logic [DATA_WIDTH-1:0] inst_readdata,
  output logic                  inst_busywait,
  input  logic                  data_read,
  input  logic                  data_write,
  input  logic [ADDR_WIDTH-1:0] data_address,
  input  logic [DATA_WIDTH-1:0] data_writedata,
  output logic [DATA_WIDTH-1:0] data_readdata,
  output logic                  data_busywait,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_writedata,
  input  logic [DATA_WIDTH-1:0] mem_readdata,
  input  logic                  mem_busywait
);

  typedef enum logic [2:0] {
    IDLE,
    INST_ACC,
    DATA_ACC,
    INST_DONE,
    DATA_DONE
  } state_e;

  typedef enum logic {
    GRANT_INST,
    GRANT_DATA
  } grant_e;

  state_e                state_q, state_d;
  grant_e                last_grant_q, last_grant_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
  logic [DATA_WIDTH-1:0] mem_writedata_q, mem_writedata_d;
  logic [DATA_WIDTH-1:0] inst_rdata_q, inst_rdata_d;
  logic [DATA_WIDTH-1:0] data_rdata_q, data_rdata_d;

  logic data_req;
  logic pick_data;

  assign data_req  = data_read | data_write;
  assign pick_data = data_req &
                     (~inst_read | (last_grant_q == GRANT_INST));

  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    mem_read_d      = mem_read_q;
    mem_write_d     = mem_write_q;
    mem_address_d   = mem_address_q;
    mem_writedata_d = mem_writedata_q;
    inst_rdata_d    = inst_rdata_q;
    data_rdata_d    = data_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (pick_data) begin
          state_d         = DATA_ACC;
          last_grant_d    = GRANT_DATA;
          mem_address_d   = data_address;
          mem_writedata_d = data_writedata;
          // a simultaneous read+write is treated as a write
          mem_write_d     = data_write;
          mem_read_d      = ~data_write;
        end else if (inst_read) begin
          state_d       = INST_ACC;
          last_grant_d  = GRANT_INST;
          mem_address_d = inst_address;
          mem_read_d    = 1'b1;
          mem_write_d   = 1'b0;
        end
      end
      INST_ACC, DATA_ACC: begin
        if (!mem_busywait) begin
          if (mem_read_q) begin
            if (state_q == INST_ACC) inst_rdata_d = mem_readdata;
            else                     data_rdata_d = mem_readdata;
          end
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = (state_q == INST_ACC) ? INST_DONE : DATA_DONE;
        end
      end
      INST_DONE, DATA_DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q         <= IDLE;
      last_grant_q    <= GRANT_INST;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
      inst_rdata_q    <= '0;
      data_rdata_q    <= '0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_address_q   <= mem_address_d;
      mem_writedata_q <= mem_writedata_d;
      inst_rdata_q    <= inst_rdata_d;
      data_rdata_q    <= data_rdata_d;
    end
  end

  assign inst_busywait = inst_read & (state_q != INST_DONE);
  assign data_busywait = data_req & (state_q != DATA_DONE);
  assign inst_readdata = inst_rdata_q;
  assign data_readdata = data_rdata_q;
  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_address   = mem_address_q;
  assign mem_writedata = mem_writedata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed timing cases, then random traffic
// against a word-array memory model with per-port expected-data queues.
module tb_mem_port_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        inst_read;
  logic [31:0] inst_address;
  logic [31:0] inst_readdata;
  logic        inst_busywait;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_address;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;
  logic        data_busywait;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .inst_read     (inst_read),
    .inst_address  (inst_address),
    .inst_readdata (inst_readdata),
    .inst_busywait (inst_busywait),
    .data_read     (data_read),
    .data_write    (data_write),
    .data_address  (data_address),
    .data_writedata(data_writedata),
    .data_readdata (data_readdata),
    .data_busywait (data_busywait),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
  );

  // Backing memory: 256 words, initial contents from a fixed hash
  logic [31:0] bmem [256];
  bit          written [256];
  int          lat = 0;
  int          cur_lat = 0;
  int          cnt = 0;
  bit          rand_lat = 1'b0;

  function automatic logic [31:0] init_val(logic [7:0] i);
    if (i == 8'd4) return 32'h00A00093;
    return ({24'b0, i} * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [31:0] rd_mem(logic [7:0] i);
    return written[i] ? bmem[i] : init_val(i);
  endfunction

  assign mem_busywait = (mem_read | mem_write) &&
                        (cnt < (rand_lat ? cur_lat : lat));
  assign mem_readdata = mem_read ? rd_mem(mem_address[9:2]) : 32'hBAD0BAD0;

  always @(posedge CLK) begin
    if (!(mem_read || mem_write)) begin
      cnt <= 0;
    end else if (mem_busywait) begin
      cnt <= cnt + 1;
    end else begin
      cnt <= 0;
      if (mem_write) begin
        bmem[mem_address[9:2]]    <= mem_writedata;
        written[mem_address[9:2]] <= 1'b1;
      end
      cur_lat <= int'($urandom_range(0, 3));
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(string nm, logic act, logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  task automatic nx();
    @(negedge CLK);
  endtask

  task automatic tkr();
    @(negedge CLK);
    #1;
  endtask

  // Scoreboard: expected readdata per completed request, in issue order
  logic [31:0] ref_mem [256];
  logic [31:0] inst_q [$];
  logic [31:0] data_q [$];
  bit          mon_en = 1'b0;

  always @(negedge CLK) begin
    if (mon_en) begin
      if (inst_read && !inst_busywait) begin
        if (inst_q.size() == 0) chk1("inst_unexpected", 1'b1, 1'b0);
        else chk("inst_rdata", inst_readdata, inst_q.pop_front());
      end
      if ((data_read || data_write) && !data_busywait) begin
        if (data_q.size() == 0) chk1("data_unexpected", 1'b1, 1'b0);
        else chk("data_rdata", data_readdata, data_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] drd;

  initial begin
    RESET = 1'b1;
    inst_read = 1'b0;
    inst_address = '0;
    data_read = 1'b0;
    data_write = 1'b0;
    data_address = '0;
    data_writedata = '0;
    nx();
    RESET = 1'b0;

    chk1("rst_mem_read", mem_read, 1'b0);
    chk1("rst_mem_write", mem_write, 1'b0);
    chk("rst_mem_address", mem_address, 32'h0);
    chk("rst_mem_writedata", mem_writedata, 32'h0);
    chk("rst_inst_readdata", inst_readdata, 32'h0);
    chk("rst_data_readdata", data_readdata, 32'h0);
    chk1("rst_inst_bw", inst_busywait, 1'b0);
    chk1("rst_data_bw", data_busywait, 1'b0);

    // single fetch, 2-cycle access
    inst_read = 1'b1;
    inst_address = 32'h10;
    #1 chk1("f_bw_c0", inst_busywait, 1'b1);
    nx();
    chk1("f_mem_read_c1", mem_read, 1'b1);
    chk("f_mem_addr_c1", mem_address, 32'h10);
    chk1("f_bw_c1", inst_busywait, 1'b1);
    nx();
    chk1("f_bw_c2", inst_busywait, 1'b0);
    chk("f_rdata_c2", inst_readdata, 32'h00A00093);
    chk1("f_mem_read_c2", mem_read, 1'b0);
    inst_read = 1'b0;
    nx();

    // tie: data first, inst after bubble, next tie back to data
    RESET = 1'b1;
    nx();
    RESET = 1'b0;
    inst_read = 1'b1;
    inst_address = 32'h20;
    data_read = 1'b1;
    data_address = 32'h100;
    nx();
    chk("tie_addr_data", mem_address, 32'h100);
    chk1("tie_mem_read", mem_read, 1'b1);
    chk1("tie_inst_bw_c1", inst_busywait, 1'b1);
    chk1("tie_data_bw_c1", data_busywait, 1'b1);
    nx();
    chk1("tie_data_bw_c2", data_busywait, 1'b0);
    chk("tie_data_rdata", data_readdata, rd_mem(8'h40));
    chk1("tie_inst_bw_c2", inst_busywait, 1'b1);
    data_address = 32'h104;
    nx();
    chk1("tie_bubble", mem_read, 1'b0);
    chk1("tie_inst_bw_c3", inst_busywait, 1'b1);
    nx();
    chk("tie_addr_inst", mem_address, 32'h20);
    chk1("tie_inst_bw_c4", inst_busywait, 1'b1);
    nx();
    chk1("tie_inst_bw_c5", inst_busywait, 1'b0);
    chk("tie_inst_rdata", inst_readdata, rd_mem(8'h08));
    chk1("tie_data_bw_c5", data_busywait, 1'b1);
    inst_address = 32'h24;
    nx();
    nx();
    chk("tie2_addr_data", mem_address, 32'h104);
    nx();
    chk1("tie2_data_bw", data_busywait, 1'b0);
    chk("tie2_data_rdata", data_readdata, rd_mem(8'h41));
    drd = rd_mem(8'h41);
    data_read = 1'b0;
    inst_read = 1'b0;
    nx();
    nx();

    // multi-cycle write, 3 busy cycles
    lat = 3;
    data_write = 1'b1;
    data_address = 32'h200;
    data_writedata = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      nx();
      chk1("mw_write_hold", mem_write, 1'b1);
      chk("mw_addr_hold", mem_address, 32'h200);
      chk("mw_wdata_hold", mem_writedata, 32'hDEADBEEF);
      chk1("mw_bw_hold", data_busywait, 1'b1);
    end
    nx();
    chk1("mw_bw_done", data_busywait, 1'b0);
    chk1("mw_write_drop", mem_write, 1'b0);
    chk("mw_rdata_kept", data_readdata, drd);
    data_write = 1'b0;
    lat = 2;
    nx();
    chk("mw_mem_content", rd_mem(8'h80), 32'hDEADBEEF);

    // fetch flushed mid-access
    inst_read = 1'b1;
    inst_address = 32'h30;
    nx();
    chk1("fl_mem_read", mem_read, 1'b1);
    chk("fl_addr", mem_address, 32'h30);
    inst_read = 1'b0;
    data_read = 1'b1;
    data_address = 32'h108;
    nx();
    chk1("fl_inst_bw_c2", inst_busywait, 1'b0);
    chk1("fl_data_bw_c2", data_busywait, 1'b1);
    chk1("fl_still_busy", mem_read, 1'b1);
    nx();
    chk1("fl_inst_bw_c3", inst_busywait, 1'b0);
    nx();
    lat = 0;
    chk("fl_inst_rdata", inst_readdata, rd_mem(8'h0C));
    chk1("fl_done_strobe", mem_read, 1'b0);
    chk1("fl_data_bw_c4", data_busywait, 1'b1);
    nx();
    chk1("fl_bubble", mem_read, 1'b0);
    nx();
    chk("fl_data_addr", mem_address, 32'h108);
    nx();
    chk1("fl_data_bw_done", data_busywait, 1'b0);
    chk("fl_data_rdata", data_readdata, rd_mem(8'h42));
    data_read = 1'b0;
    nx();

    // reset during a 5-cycle data read
    lat = 4;
    data_read = 1'b1;
    data_address = 32'h10C;
    nx();
    chk1("rm_strobe", mem_read, 1'b1);
    nx();
    RESET = 1'b1;
    nx();
    RESET = 1'b0;
    lat = 0;
    chk1("rm_strobe_drop", mem_read, 1'b0);
    chk("rm_addr_reset", mem_address, 32'h0);
    chk1("rm_data_bw", data_busywait, 1'b1);
    chk("rm_rdata_reset", data_readdata, 32'h0);
    nx();
    chk1("rm_reissue", mem_read, 1'b1);
    chk("rm_reissue_addr", mem_address, 32'h10C);
    nx();
    chk1("rm_bw_done", data_busywait, 1'b0);
    chk("rm_rdata", data_readdata, rd_mem(8'h43));
    drd = rd_mem(8'h43);
    data_read = 1'b0;
    nx();

    // illegal read+write behaves as a write
    data_read = 1'b1;
    data_write = 1'b1;
    data_address = 32'h204;
    data_writedata = 32'h12345678;
    nx();
    chk1("rw_mem_write", mem_write, 1'b1);
    chk1("rw_mem_read", mem_read, 1'b0);
    chk("rw_wdata", mem_writedata, 32'h12345678);
    nx();
    chk1("rw_bw_done", data_busywait, 1'b0);
    chk("rw_rdata_kept", data_readdata, drd);
    data_read = 1'b0;
    data_write = 1'b0;
    nx();
    chk("rw_mem_content", rd_mem(8'h81), 32'h12345678);

    // random traffic on both ports
    RESET = 1'b1;
    nx();
    RESET = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = rd_mem(8'(i));
    rand_lat = 1'b1;
    mon_en = 1'b1;
    fork
      begin : inst_drv
        logic [31:0] ia;
        int ik;
        for (int n = 0; n < 150; n++) begin
          repeat ($urandom_range(0, 3)) tkr();
          ia = {23'b0, 7'($urandom_range(0, 127)), 2'b00};
          inst_q.push_back(ref_mem[ia[9:2]]);
          inst_read = 1'b1;
          inst_address = ia;
          ik = 0;
          do begin
            tkr();
            ik++;
          end while (inst_busywait && ik < 100);
          chk1("inst_timeout", inst_busywait, 1'b0);
          inst_read = 1'b0;
        end
      end
      begin : data_drv
        logic [31:0] da;
        logic [31:0] dw;
        logic [31:0] last_rd;
        int dk;
        int op;
        last_rd = 32'h0;
        for (int n = 0; n < 150; n++) begin
          repeat ($urandom_range(0, 3)) tkr();
          op = int'($urandom_range(0, 9));
          if (op < 5) begin
            da = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
            last_rd = ref_mem[da[9:2]];
            data_q.push_back(last_rd);
            data_read = 1'b1;
            data_write = 1'b0;
          end else begin
            da = {22'b0, 1'b1, 7'($urandom_range(0, 127)), 2'b00};
            dw = $urandom;
            ref_mem[da[9:2]] = dw;
            data_q.push_back(last_rd);
            data_read = (op == 9);
            data_write = 1'b1;
            data_writedata = dw;
          end
          data_address = da;
          dk = 0;
          do begin
            tkr();
            dk++;
          end while (data_busywait && dk < 100);
          chk1("data_timeout", data_busywait, 1'b0);
          data_read = 1'b0;
          data_write = 1'b0;
        end
      end
    join
    repeat (4) nx();
    mon_en = 1'b0;
    chk("inst_q_left", 32'(inst_q.size()), 32'h0);
    chk("data_q_left", 32'(data_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares a single multi-cycle backing memory between the instruction-fetch port and the data-memory port of the RV32IM pipeline.
- Sequences every access with a small FSM and drives the per-port busywait signals that the fetch stage ORs into its PC-update stall.
- Data port has priority on ties; alternating-priority prevents instruction starvation.

Parameters:
- ADDR_WIDTH, 32, width of all address buses
- DATA_WIDTH, 32, width of all data buses

Ports:
- CLK  input  1  system clock, all state updates on posedge
- RESET  input  1  synchronous, active-high reset
- inst_read  input  1  fetch-stage read request, held until inst_busywait low
- inst_address  input  ADDR_WIDTH  fetch address (PC)
- inst_readdata  output  DATA_WIDTH  fetched word, valid while inst_busywait low after a completed access
- inst_busywait  output  1  fetch-port stall
- data_read  input  1  data-port read request
- data_write  input  1  data-port write request
- data_address  input  ADDR_WIDTH  data address
- data_writedata  input  DATA_WIDTH  store data
- data_readdata  output  DATA_WIDTH  load data
- data_busywait  output  1  data-port stall
- mem_read  output  1  backing-memory read strobe (registered)
- mem_write  output  1  backing-memory write strobe (registered)
- mem_address  output  ADDR_WIDTH  backing-memory address (registered)
- mem_writedata  output  DATA_WIDTH  backing-memory write data (registered)
- mem_readdata  input  DATA_WIDTH  backing-memory read data
- mem_busywait  input  1  backing memory busy; access completes on a posedge with mem_busywait low

Behaviour:
- Clock and reset: one clock (CLK). RESET is synchronous and active-high.
- Reset values:
  - FSM state IDLE; last_grant set to INST, so the first tie goes to the data port.
  - mem_read=0, mem_write=0, mem_address=0, mem_writedata=0, inst_readdata=0, data_readdata=0.
- FSM states: IDLE, INST_ACC, DATA_ACC, INST_DONE, DATA_DONE.
- IDLE, evaluated at posedge:
  - Only a data request (data_read|data_write) pending -> DATA_ACC.
  - Only inst_read pending -> INST_ACC.
  - Both pending: grant the port not in last_grant.
  - The granted port's address and write data are latched into the mem_* registers. mem_read or mem_write is set in the same edge.
  - last_grant is updated to the granted port.
- DATA_ACC and INST_ACC, evaluated at each posedge:
  - mem_busywait=1 -> hold state and all mem_* outputs.
  - mem_busywait=0 -> capture mem_readdata into the granted port's readdata register (reads only), clear mem_read/mem_write, go to the matching DONE state.
- INST_DONE and DATA_DONE last exactly one cycle, then -> IDLE. A new grant can issue on the posedge that leaves IDLE, so there is one idle bubble cycle between back-to-back accesses.
- inst_busywait is combinational: inst_read & (state != INST_DONE).
- data_busywait is combinational: (data_read|data_write) & (state != DATA_DONE).
- A port with no request always sees busywait=0.
- Minimum latency: request in cycle 0, mem strobe in cycle 1, with mem_busywait=0 busywait low in cycle 2 (2-cycle access). Each extra mem_busywait cycle adds one cycle.
- Address and data changes on a port during its own access are ignored, because values are latched at grant.
- Request deasserted mid-access (e.g. fetch flush on a jump or branch):
  - The memory transaction completes normally.
  - readdata is still updated on reads.
  - The DONE state is still visited, and busywait stays low because the request is low.
- data_read and data_write both high is illegal. Write takes precedence: mem_write=1, mem_read=0, data_readdata is not updated.
- Writes never modify data_readdata or inst_readdata.
- readdata registers hold their last value until the next completed read on that port.
- RESET asserted mid-access:
  - On that posedge the state goes to IDLE and the mem_* strobes drop, along with the other reset values.
  - The backing memory must tolerate an aborted strobe.
  - Busywaits then follow the raw requests, high if a request is present, until a new access completes.
- mem_readdata is sampled only on the completing edge. It is don't-care otherwise.

Test Plan:
- Reset then single fetch:
  - Stimulus: RESET 1 cycle; inst_read=1, inst_address=0x00000010; memory returns 0x00A00093 with mem_busywait=0.
  - Required: mem_read=1 and mem_address=0x10 in cycle 1; inst_busywait low in cycle 2 with inst_readdata=0x00A00093; all reset values checked beforehand.
- Simultaneous requests:
  - Stimulus: after reset, inst_read and data_read at 0x100 together.
  - Required: data granted first; inst granted next, after the bubble; inst_busywait high throughout the data access. A second tie after that inst grant goes to data.
- Multi-cycle memory:
  - Stimulus: data_write to 0x200 with 0xDEADBEEF; mem_busywait=1 for 3 cycles.
  - Required: mem_write, mem_address=0x200 and mem_writedata=0xDEADBEEF held for 4 cycles; data_busywait low exactly in the DATA_DONE cycle; data_readdata unchanged.
- Fetch flush:
  - Stimulus: inst_read deasserted during INST_ACC.
  - Required: access completes; inst_busywait=0 throughout; next data request granted from IDLE after INST_DONE.
- Reset mid-access:
  - Stimulus: RESET asserted in cycle 2 of a 5-cycle data read.
  - Required: mem_read=0 after that posedge; state IDLE; data_busywait=1 while data_read stays high; a fresh access is issued after RESET drops.
- Illegal read+write:
  - Stimulus: data_read=data_write=1.
  - Required: mem_write=1, mem_read=0, data_readdata holds its prior value.
